// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//   Drives a PLL's reset input, waits for its lock indicator, qualifies lock
//   stability and then releases a downstream system reset. If lock is lost,
//   or does not arrive in time, the system reset is reasserted and the PLL is
//   retried. After MAX_RETRIES consecutive timeouts the block parks in FAIL.
//
//   Optional feature: define PLL_LOCK_LOSS_COUNT_EN to build a saturating
//   8-bit counter of lock-loss events (RUN -> RESET_PLL). Without the macro
//   loss_cnt is a constant zero and no counter register exists.
//
//   Handshake/timing notes: force_relock is a single-cycle request sampled on
//   refclk and overrides every other transition. pll_locked is asynchronous
//   and is only ever used through a 2-flop synchronizer (locked_s).
module pll_lock_supervisor #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 8
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       fail,
    output logic [2:0] state,
    output logic [7:0] loss_cnt
);

    // Timers share one width: large enough for the biggest terminal count.
    localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_P  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int unsigned TW     = $clog2(MAX_P + 1);
    localparam int unsigned RW     = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [TW-1:0]   stable_q, stable_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic [RW-1:0]   retry_inc;
    logic [1:0]      sync_q, sync_d;
    logic            pll_rst_q, pll_rst_d;
    logic            sys_rst_q, sys_rst_d;
    logic            fail_q, fail_d;
    logic            locked_s;

    // Two-flop synchronizer for the asynchronous lock indicator.
    always_comb begin
        sync_d = {sync_q[0], pll_locked};
    end

    assign locked_s  = sync_q[1];
    assign retry_inc = retry_q + RW'(1);

`ifdef PLL_LOCK_LOSS_COUNT_EN
    logic       loss_inc;
    logic [7:0] loss_cnt_q, loss_cnt_d;
`endif

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        stable_d = stable_q;
        retry_d  = retry_q;
`ifdef PLL_LOCK_LOSS_COUNT_EN
        loss_inc = 1'b0;
`endif
        if (force_relock) begin
            // Restart the whole sequence; a requested relock is not a loss.
            state_d  = S_RESET_PLL;
            timer_d  = '0;
            stable_d = '0;
            retry_d  = '0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (timer_q == TW'(RST_CYCLES - 1)) begin
                        state_d = S_WAIT_LOCK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    // Lock wins over a timeout on the same cycle.
                    if (locked_s) begin
                        state_d  = S_STABLE;
                        stable_d = TW'(1);
                        timer_d  = '0;
                    end else if (timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                        retry_d = retry_inc;
                        timer_d = '0;
                        if (retry_inc == RW'(MAX_RETRIES)) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d = S_RESET_PLL;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_STABLE: begin
                    if (!locked_s) begin
                        // Lock glitched while qualifying: wait again, no retry.
                        state_d  = S_WAIT_LOCK;
                        timer_d  = '0;
                        stable_d = '0;
                    end else if (stable_q == TW'(STABLE_CYCLES)) begin
                        state_d  = S_RUN;
                        stable_d = '0;
                        retry_d  = '0;
                    end else begin
                        stable_d = stable_q + TW'(1);
                    end
                end
                S_RUN: begin
                    if (!locked_s) begin
                        state_d  = S_RESET_PLL;
                        timer_d  = '0;
                        stable_d = '0;
`ifdef PLL_LOCK_LOSS_COUNT_EN
                        loss_inc = 1'b1;
`endif
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d  = S_RESET_PLL;
                    timer_d  = '0;
                    stable_d = '0;
                    retry_d  = '0;
                end
            endcase
        end

        // Outputs are registered copies of a decode of the next state.
        pll_rst_d = (state_d == S_RESET_PLL);
        sys_rst_d = (state_d != S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    // State, counters and output registers with asynchronous reset.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET_PLL;
            timer_q   <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            sync_q    <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            sync_q    <= sync_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            fail_q    <= fail_d;
        end
    end

`ifdef PLL_LOCK_LOSS_COUNT_EN
    // Saturating lock-loss counter; cleared only by rst.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (loss_inc && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    // Lock-loss counter register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign loss_cnt = loss_cnt_q;
`else
    assign loss_cnt = 8'd0;
`endif

    assign pll_rst = pll_rst_q;
    assign sys_rst = sys_rst_q;
    assign fail    = fail_q;
    assign state   = state_q;

endmodule
